rpu_or_buffer: RTL and testbench
================================

RPU_OR_BUFFER -- requirements
Module: rpu_or_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of outbound-response FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter CNT_W, default 8, meaning the width of the dropped-response counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port or_valid, input, 1 bit: an encoded outbound response is present this cycle.
REQ-006 SHALL have port or_dat_tid, input, `NOU_TID_WIDTH bits: response transaction id.
REQ-007 SHALL have port or_dat_type, input, `NOU_TYPE_WIDTH bits: response type.
REQ-008 SHALL have port or_dat_data, input, `NOU_NOC_RSP_WIDTH bits: response payload.
REQ-009 SHALL have port or_ready, output, 1 bit: the buffer can accept a response this cycle.
REQ-010 SHALL have port noc_rsp_vld, output, 1 bit: the head response is presented to the NoC.
REQ-011 SHALL have port noc_rsp_rdy, input, 1 bit: the NoC accepts the presented response.
REQ-012 SHALL have port noc_rsp_tid, output, `NOU_TID_WIDTH bits: head transaction id.
REQ-013 SHALL have port noc_rsp_type, output, `NOU_TYPE_WIDTH bits: head type.
REQ-014 SHALL have port noc_rsp_data, output, `NOU_NOC_RSP_WIDTH bits: head payload.
REQ-015 SHALL have port occupancy, output, $clog2(DEPTH)+1 bits: current entry count.
REQ-016 SHALL have port ovf_err, output, 1 bit: sticky flag set when a response was dropped.
REQ-017 SHALL have port drop_cnt, output, CNT_W bits: count of dropped responses.
REQ-018 SHALL have port err_clr, input, 1 bit: single-cycle pulse that clears ovf_err and drop_cnt.

Function
REQ-019 SHALL store {tid, type, data} in a circular FIFO of DEPTH entries, addressed by write and read pointers that are one bit wider than the index.
REQ-020 SHALL drive or_ready = (occupancy != DEPTH), derived only from registered state and with no combinational path from noc_rsp_rdy.
REQ-021 SHALL push when or_valid && or_ready, writing to the entry at the write pointer and incrementing the write pointer.
REQ-022 SHALL pop when noc_rsp_vld && noc_rsp_rdy, incrementing the read pointer.
REQ-023 SHALL drive noc_rsp_vld = (occupancy != 0) and noc_rsp_{tid,type,data} from the entry at the read pointer.
REQ-024 SHALL give a latency of 1 cycle: a response pushed at edge N is presented with noc_rsp_vld=1 after edge N.
REQ-025 SHALL hold the noc_rsp_* fields stable while noc_rsp_vld=1 and noc_rsp_rdy=0.
REQ-026 SHALL, on a simultaneous push and pop, leave occupancy unchanged and advance both pointers.
REQ-027 SHALL, when full, not push even if a pop occurs in the same cycle, because or_ready is low.
REQ-028 SHALL wrap both pointers modulo 2*DEPTH, so that the index is the low bits and the extra MSB distinguishes full from empty.
REQ-029 SHALL treat or_valid && !or_ready as a drop: the response is discarded, ovf_err is set to 1 at the next edge, and drop_cnt increments and saturates at 2^CNT_W-1.
REQ-030 SHALL give err_clr priority over a same-cycle drop: ovf_err=0 and drop_cnt=0 at the next edge.
REQ-031 SHALL treat noc_rsp_rdy=1 while empty as a no-op.
REQ-032 SHALL keep FIFO contents visible only through noc_rsp_*; unused entries are don't-care.

Reset
REQ-033 SHALL, while rst_n=0, immediately clear the pointers, occupancy, ovf_err and drop_cnt, so that noc_rsp_vld=0 and or_ready=1.
REQ-034 SHALL discard in-flight entries when reset is asserted mid-operation, with no pop handshake.
REQ-035 SHALL accept a push on the first rising edge after rst_n deasserts.
REQ-036 SHALL have FIFO storage that is not reset; noc_rsp_tid, noc_rsp_type and noc_rsp_data are don't-care while noc_rsp_vld=0.

Verification
REQ-037 Bench SHALL check: single push of tid=5, type=2, data=0x3A with noc_rsp_rdy=1 -> noc_rsp_vld=1 for exactly one cycle with tid=5, type=2, data=0x3A, then occupancy returns to 0.
REQ-038 Bench SHALL check: 4 pushes with noc_rsp_rdy=0 and DEPTH=4 -> occupancy=4, or_ready=0; a 5th or_valid -> ovf_err=1, drop_cnt=1; the head remains the first response.
REQ-039 Bench SHALL check: full FIFO with noc_rsp_rdy=1 and or_valid=1 each cycle -> no push in the full cycle and a drop counted; afterwards one pop and one push per cycle with occupancy steady at 3; output order is FIFO.
REQ-040 Bench SHALL check: 20 responses streamed with random noc_rsp_rdy -> the ordered scoreboard matches, the pointers wrap at least twice, and no spurious drop occurs while or_valid is gated by or_ready.
REQ-041 Bench SHALL check: rst_n pulled low with 3 entries held -> noc_rsp_vld=0, occupancy=0 and or_ready=1 asynchronously, before any clock edge.
REQ-042 Bench SHALL check: err_clr asserted in the same cycle as a drop with drop_cnt=7 -> ovf_err=0 and drop_cnt=0 next cycle; drop_cnt forced near max -> saturates at 255.

Source files
------------

// File: rtl/rpu_or_buffer.sv
// rpu_or_buffer: outbound-response FIFO between the RPU response encoder and the NoC.
//
// Ports:
//   clk, rst_n                   clock and asynchronous active-low reset
//   or_valid / or_ready          encoder-side handshake; or_valid while !or_ready is a drop
//   or_dat_tid/type/data         response fields to enqueue
//   noc_rsp_vld / noc_rsp_rdy    NoC-side handshake for the head entry
//   noc_rsp_tid/type/data        head entry fields (don't-care while noc_rsp_vld=0)
//   occupancy                    current number of stored entries
//   ovf_err, drop_cnt            sticky drop flag and saturating drop counter
//   err_clr                      single-cycle clear of ovf_err/drop_cnt (wins over a drop)

`ifndef NOU_TID_WIDTH
`define NOU_TID_WIDTH 8
`endif
`ifndef NOU_TYPE_WIDTH
`define NOU_TYPE_WIDTH 4
`endif
`ifndef NOU_NOC_RSP_WIDTH
`define NOU_NOC_RSP_WIDTH 32
`endif

module rpu_or_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            or_valid,
    input  logic [`NOU_TID_WIDTH-1:0]       or_dat_tid,
    input  logic [`NOU_TYPE_WIDTH-1:0]      or_dat_type,
    input  logic [`NOU_NOC_RSP_WIDTH-1:0]   or_dat_data,
    output logic                            or_ready,
    output logic                            noc_rsp_vld,
    input  logic                            noc_rsp_rdy,
    output logic [`NOU_TID_WIDTH-1:0]       noc_rsp_tid,
    output logic [`NOU_TYPE_WIDTH-1:0]      noc_rsp_type,
    output logic [`NOU_NOC_RSP_WIDTH-1:0]   noc_rsp_data,
    output logic [$clog2(DEPTH):0]          occupancy,
    output logic                            ovf_err,
    output logic [CNT_W-1:0]                drop_cnt,
    input  logic                            err_clr
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned TW = `NOU_TID_WIDTH;
    localparam int unsigned YW = `NOU_TYPE_WIDTH;
    localparam int unsigned DW = `NOU_NOC_RSP_WIDTH;
    localparam int unsigned EW = TW + YW + DW;

    localparam logic [PW-1:0]    FULL_CNT = PW'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    // Storage is intentionally not reset; only the pointers define validity.
    logic [EW-1:0] r_mem [DEPTH];

    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic             r_ovf;
    logic [CNT_W-1:0] r_drop_cnt;

    logic [PW-1:0] w_occ;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_drop;
    logic [EW-1:0] w_head;

    // Pointers carry an extra wrap bit, so the modulo-2*DEPTH difference is the fill level.
    assign w_occ   = r_wptr - r_rptr;
    assign w_full  = (w_occ == FULL_CNT);
    assign w_empty = (w_occ == '0);

    // or_ready depends on registered pointers only; a same-cycle pop does not open a slot.
    assign w_push = or_valid && !w_full;
    assign w_drop = or_valid && w_full;
    assign w_pop  = !w_empty && noc_rsp_rdy;

    assign w_head = r_mem[r_rptr[AW-1:0]];

    assign or_ready     = !w_full;
    assign noc_rsp_vld  = !w_empty;
    assign noc_rsp_tid  = w_head[EW-1 -: TW];
    assign noc_rsp_type = w_head[DW +: YW];
    assign noc_rsp_data = w_head[DW-1:0];
    assign occupancy    = w_occ;
    assign ovf_err      = r_ovf;
    assign drop_cnt     = r_drop_cnt;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= {or_dat_tid, or_dat_type, or_dat_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
        end
    end

    // err_clr takes priority over a drop in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf      <= 1'b0;
            r_drop_cnt <= '0;
        end else if (err_clr) begin
            r_ovf      <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
            if (r_drop_cnt != CNT_MAX) r_drop_cnt <= r_drop_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_rpu_or_buffer.sv
// tb_rpu_or_buffer: directed self-checking bench for rpu_or_buffer (DEPTH=4, CNT_W=8).
// Inputs change and outputs are sampled on the falling clock edge.

`ifndef NOU_TID_WIDTH
`define NOU_TID_WIDTH 8
`endif
`ifndef NOU_TYPE_WIDTH
`define NOU_TYPE_WIDTH 4
`endif
`ifndef NOU_NOC_RSP_WIDTH
`define NOU_NOC_RSP_WIDTH 32
`endif

module tb_rpu_or_buffer;

    logic                            clk = 1'b0;
    logic                            rst_n;
    logic                            or_valid;
    logic [`NOU_TID_WIDTH-1:0]       or_dat_tid;
    logic [`NOU_TYPE_WIDTH-1:0]      or_dat_type;
    logic [`NOU_NOC_RSP_WIDTH-1:0]   or_dat_data;
    logic                            or_ready;
    logic                            noc_rsp_vld;
    logic                            noc_rsp_rdy;
    logic [`NOU_TID_WIDTH-1:0]       noc_rsp_tid;
    logic [`NOU_TYPE_WIDTH-1:0]      noc_rsp_type;
    logic [`NOU_NOC_RSP_WIDTH-1:0]   noc_rsp_data;
    logic [2:0]                      occupancy;
    logic                            ovf_err;
    logic [7:0]                      drop_cnt;
    logic                            err_clr;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rpu_or_buffer #(
        .DEPTH (4),
        .CNT_W (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .or_valid     (or_valid),
        .or_dat_tid   (or_dat_tid),
        .or_dat_type  (or_dat_type),
        .or_dat_data  (or_dat_data),
        .or_ready     (or_ready),
        .noc_rsp_vld  (noc_rsp_vld),
        .noc_rsp_rdy  (noc_rsp_rdy),
        .noc_rsp_tid  (noc_rsp_tid),
        .noc_rsp_type (noc_rsp_type),
        .noc_rsp_data (noc_rsp_data),
        .occupancy    (occupancy),
        .ovf_err      (ovf_err),
        .drop_cnt     (drop_cnt),
        .err_clr      (err_clr)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] tid, input logic [3:0] typ,
                         input logic [31:0] dat);
        or_valid    = v;
        or_dat_tid  = tid;
        or_dat_type = typ;
        or_dat_data = dat;
    endtask

    logic [7:0]  q_tid [$];
    logic [31:0] q_dat [$];

    initial begin
        int sent;
        int recv;
        int cyc;
        rst_n       = 1'b0;
        noc_rsp_rdy = 1'b0;
        err_clr     = 1'b0;
        drive(1'b0, 8'h0, 4'h0, 32'h0);

        // Reset state, before any clock edge.
        #2;
        chk("rst_vld", 64'(noc_rsp_vld), 64'd0);
        chk("rst_occ", 64'(occupancy), 64'd0);
        chk("rst_rdy", 64'(or_ready), 64'd1);
        chk("rst_ovf", 64'(ovf_err), 64'd0);
        chk("rst_cnt", 64'(drop_cnt), 64'd0);

        // Single push on the first edge after reset release, NoC ready.
        #1;
        rst_n       = 1'b1;
        noc_rsp_rdy = 1'b1;
        drive(1'b1, 8'd5, 4'd2, 32'h3A);
        @(negedge clk);
        chk("single_vld", 64'(noc_rsp_vld), 64'd1);
        chk("single_tid", 64'(noc_rsp_tid), 64'd5);
        chk("single_type", 64'(noc_rsp_type), 64'd2);
        chk("single_data", 64'(noc_rsp_data), 64'h3A);
        chk("single_occ1", 64'(occupancy), 64'd1);
        drive(1'b0, 8'h0, 4'h0, 32'h0);
        @(negedge clk);
        chk("single_vld_off", 64'(noc_rsp_vld), 64'd0);
        chk("single_occ0", 64'(occupancy), 64'd0);

        // Fill with NoC stalled, then one dropped response.
        noc_rsp_rdy = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 8'(i), 4'(i), 32'h10 + 32'(i));
            @(negedge clk);
        end
        chk("full_occ", 64'(occupancy), 64'd4);
        chk("full_rdy", 64'(or_ready), 64'd0);
        drive(1'b1, 8'd9, 4'd9, 32'h99);
        @(negedge clk);
        chk("drop_ovf", 64'(ovf_err), 64'd1);
        chk("drop_cnt1", 64'(drop_cnt), 64'd1);
        chk("drop_head_tid", 64'(noc_rsp_tid), 64'd1);
        chk("drop_head_data", 64'(noc_rsp_data), 64'h11);
        chk("drop_occ", 64'(occupancy), 64'd4);

        // Full with pop and push offered together: pop only, the push is a drop.
        noc_rsp_rdy = 1'b1;
        drive(1'b1, 8'h20, 4'h0, 32'h20);
        @(negedge clk);
        chk("fullpop_occ", 64'(occupancy), 64'd3);
        chk("fullpop_cnt", 64'(drop_cnt), 64'd2);
        chk("fullpop_head", 64'(noc_rsp_tid), 64'd2);
        chk("fullpop_rdy", 64'(or_ready), 64'd1);
        // Steady state: heads 3, 4, then 0x21 onward; 0x20 was dropped.
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 8'h21 + 8'(i), 4'h0, 32'h21 + 32'(i));
            @(negedge clk);
            chk("steady_occ", 64'(occupancy), 64'd3);
            chk("steady_head", 64'(noc_rsp_tid), (i == 0) ? 64'd3 :
                                                  (i == 1) ? 64'd4 : 64'h1F + 64'(i));
        end
        chk("steady_cnt", 64'(drop_cnt), 64'd2);
        drive(1'b0, 8'h0, 4'h0, 32'h0);
        repeat (3) @(negedge clk);
        chk("drain_occ", 64'(occupancy), 64'd0);

        // Streaming with random backpressure and or_valid gated by or_ready.
        sent = 0;
        recv = 0;
        cyc  = 0;
        while (recv < 20 && cyc < 500) begin
            chk("stream_vld", 64'(noc_rsp_vld), 64'(q_tid.size() != 0));
            noc_rsp_rdy = 1'($urandom_range(0, 1));
            if (noc_rsp_vld && noc_rsp_rdy && q_tid.size() != 0) begin
                chk("stream_tid", 64'(noc_rsp_tid), 64'(q_tid.pop_front()));
                chk("stream_data", 64'(noc_rsp_data), 64'(q_dat.pop_front()));
                recv++;
            end
            if (or_ready && sent < 20) begin
                drive(1'b1, 8'h40 + 8'(sent), 4'(sent), 32'hA000_0000 + 32'(sent));
                q_tid.push_back(8'h40 + 8'(sent));
                q_dat.push_back(32'hA000_0000 + 32'(sent));
                sent++;
            end else begin
                drive(1'b0, 8'h0, 4'h0, 32'h0);
            end
            @(negedge clk);
            cyc++;
        end
        chk("stream_recv", 64'(recv), 64'd20);
        chk("stream_nodrop", 64'(drop_cnt), 64'd2);
        drive(1'b0, 8'h0, 4'h0, 32'h0);
        noc_rsp_rdy = 1'b0;
        @(negedge clk);
        chk("stream_empty", 64'(occupancy), 64'd0);

        // Asynchronous reset with 3 entries held.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'h60 + 8'(i), 4'h1, 32'h60);
            @(negedge clk);
        end
        drive(1'b0, 8'h0, 4'h0, 32'h0);
        chk("pre_rst_occ", 64'(occupancy), 64'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_vld", 64'(noc_rsp_vld), 64'd0);
        chk("arst_occ", 64'(occupancy), 64'd0);
        chk("arst_rdy", 64'(or_ready), 64'd1);
        chk("arst_cnt", 64'(drop_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // err_clr against a same-cycle drop, with drop_cnt=7.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'h70 + 8'(i), 4'h2, 32'h70);
            @(negedge clk);
        end
        repeat (7) @(negedge clk);
        chk("clr_pre_cnt", 64'(drop_cnt), 64'd7);
        chk("clr_pre_ovf", 64'(ovf_err), 64'd1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("clr_ovf", 64'(ovf_err), 64'd0);
        chk("clr_cnt", 64'(drop_cnt), 64'd0);
        chk("clr_head", 64'(noc_rsp_tid), 64'h70);

        // Saturation: 260 consecutive drops.
        repeat (260) @(negedge clk);
        chk("sat_cnt", 64'(drop_cnt), 64'd255);
        chk("sat_ovf", 64'(ovf_err), 64'd1);
        drive(1'b0, 8'h0, 4'h0, 32'h0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("sat_clr_cnt", 64'(drop_cnt), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
